// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the PC and issues sequential reads to a 1-cycle-latency instruction memory.
// Returned {pc, instruction} pairs are buffered in a DEPTH-entry FIFO and offered
// to the decoder through a valid/ready handshake. Requests are only issued when
// the FIFO is guaranteed to have room for the response: credit = DEPTH - count - inflight.
// A redirect clears the FIFO, drops the response arriving in the same cycle and
// restarts fetching at the word-aligned target.
// Optional feature: define FETCH_PERF_CNT_EN to add saturating stall/redirect counters.

// Overflow guard for the output FIFO, kept apart from the datapath.
module fetch_unit_chk #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst_n,
    input logic             push,
    input logic             pop,
    input logic [CNT_W-1:0] count
);
    // A response may only land in a full FIFO if the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CNT_W'(DEPTH))));
endmodule

module fetch_unit #(
    parameter int              PC_W     = 9,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] PC_RESET = 9'h000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_redirect_valid,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [PC_W-1:0]    o_pc,
    output logic [INSTR_W-1:0] o_instruction
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        o_stall_cycles,
    output logic [15:0]        o_redirect_cnt
`endif
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    addr_q, addr_d;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PC_W-1:0]    fifo_pc_q  [DEPTH];
    logic [PC_W-1:0]    fifo_pc_d  [DEPTH];
    logic [INSTR_W-1:0] fifo_ins_q [DEPTH];
    logic [INSTR_W-1:0] fifo_ins_d [DEPTH];

    logic [CNT_W:0]     used_s;
    logic               pop_s;
    logic               push_s;
    logic               req_s;
    logic               credit_s;
    logic               credit_pop_s;

    // Slots already spoken for: buffered entries plus the response still in flight.
    assign used_s       = (CNT_W + 1)'(count_q) + (CNT_W + 1)'(inflight_q);
    assign credit_s     = (used_s < DEPTH_L);
    assign credit_pop_s = (used_s < (DEPTH_L + (CNT_W + 1)'(pop_s)));
    assign pop_s        = (count_q != {CNT_W{1'b0}}) && i_ready;
    // The response of last cycle's request; a redirect this cycle drops it.
    assign push_s       = inflight_q && !i_redirect_valid;

    // Fetch sequencing: issue while credit lasts, park in S_HOLD when it runs out.
    always_comb begin
        state_d = state_q;
        req_s   = 1'b0;
        if (i_redirect_valid) begin
            state_d = S_FETCH;
            req_s   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (credit_s) begin
                        req_s = 1'b1;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (credit_pop_s) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // PC advance / redirect target, and the address tag for the pending response.
    always_comb begin
        pc_d       = pc_q;
        addr_d     = addr_q;
        inflight_d = req_s;
        if (i_redirect_valid) begin
            pc_d = i_redirect_pc & ~{{(PC_W-2){1'b0}}, 2'b11};
        end else if (req_s) begin
            pc_d   = pc_q + PC_W'(4);
            addr_d = pc_q;
        end else begin
            pc_d = pc_q;
        end
    end

    // Output FIFO bookkeeping: push response, pop on handshake, clear on redirect.
    always_comb begin
        fifo_pc_d  = fifo_pc_q;
        fifo_ins_d = fifo_ins_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (i_redirect_valid) begin
            rd_ptr_d = {AW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_pc_d[wr_ptr_q]  = addr_q;
                fifo_ins_d[wr_ptr_q] = i_imem_rdata;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, PC and FIFO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_RESET;
            addr_q     <= PC_RESET;
            inflight_q <= 1'b0;
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            wr_ptr_q   <= {AW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]  <= {PC_W{1'b0}};
                fifo_ins_q[i] <= {INSTR_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_ins_q <= fifo_ins_d;
        end
    end

    assign o_imem_req    = req_s;
    assign o_imem_addr   = pc_q;
    assign o_valid       = (count_q != {CNT_W{1'b0}});
    assign o_pc          = fifo_pc_q[rd_ptr_q];
    assign o_instruction = fifo_ins_q[rd_ptr_q];

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] redir_cnt_q, redir_cnt_d;

    // Saturating counts of decoder back-pressure cycles and redirects taken.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (o_valid && !i_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (i_redirect_valid && (redir_cnt_q != 16'hFFFF)) begin
            redir_cnt_d = redir_cnt_q + 16'd1;
        end else begin
            redir_cnt_d = redir_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            redir_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign o_stall_cycles = stall_cnt_q;
    assign o_redirect_cnt = redir_cnt_q;
`endif

    fetch_unit_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_q)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference model tracks only the
// architectural promise: the next PC the decoder must see, the instruction that
// memory holds at that PC, and the fixed cycle distances after reset release
// and after a redirect.
module tb_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        o_imem_req;
    logic [8:0]  o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        i_redirect_valid;
    logic [8:0]  i_redirect_pc;
    logic        o_valid;
    logic        i_ready;
    logic [8:0]  o_pc;
    logic [31:0] o_instruction;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] o_stall_cycles;
    logic [15:0] o_redirect_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  exp_pc;
    logic [8:0]  tgt;
    int          since;
    logic        prev_stall;
    logic [8:0]  prev_pc;
    logic [31:0] prev_ins;
    int          req_total;
    int          pop_total;

    fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rdata     (i_imem_rdata),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_pc             (o_pc),
        .o_instruction    (o_instruction)
`ifdef FETCH_PERF_CNT_EN
        ,
        .o_stall_cycles   (o_stall_cycles),
        .o_redirect_cnt   (o_redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [8:0] a);
        return {16'hC0DE, 7'd0, a};
    endfunction

    // Instruction memory: data one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        if (o_imem_req) i_imem_rdata <= mem_f(o_imem_addr);
        else            i_imem_rdata <= $urandom;
        if (rst_n && o_imem_req) req_total = req_total + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_ready = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc = 9'h000;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_req", o_imem_req, 1'b0);
        chk("rst_addr", o_imem_addr, 9'h000);
        chk("rst_pc", o_pc, 9'h000);
        chk("rst_instr", o_instruction, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_stall_cnt", o_stall_cycles, 16'h0);
        chk("rst_redir_cnt", o_redirect_cnt, 16'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 9'h000;
        tgt = 9'h000;
        since = 0;
        prev_stall = 1'b0;
        req_total = 0;
        pop_total = 0;
    endtask

    // One cycle: drive inputs, then check outputs against the reference model.
    task automatic step(input logic rdy, input logic rv, input logic [8:0] rpc);
        @(negedge clk);
        i_ready = rdy;
        i_redirect_valid = rv;
        i_redirect_pc = rpc;
        #1;
        since = since + 1;
        if (since == 1 && !rv) begin
            chk("req_after_restart", o_imem_req, 1'b1);
            chk("addr_after_restart", o_imem_addr, tgt);
        end
        if (since == 1 || since == 2) chk("valid_gap", o_valid, 1'b0);
        if (since == 3) chk("valid_at_t3", o_valid, 1'b1);
        if (rv) chk("no_req_on_redirect", o_imem_req, 1'b0);
        if (prev_stall && since > 1) begin
            chk("stall_valid_held", o_valid, 1'b1);
            chk("stall_pc_held", o_pc, prev_pc);
            chk("stall_instr_held", o_instruction, prev_ins);
        end
        if (o_valid === 1'b1) begin
            chk("head_pc", o_pc, exp_pc);
            chk("head_instr", o_instruction, mem_f(exp_pc));
            if (rdy) begin
                exp_pc = exp_pc + 9'd4;
                pop_total++;
            end
        end
        prev_stall = (o_valid === 1'b1) && !rdy;
        prev_pc = o_pc;
        prev_ins = o_instruction;
        if (rv) begin
            exp_pc = rpc & 9'h1FC;
            tgt = rpc & 9'h1FC;
            since = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_ready = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc = 9'h000;
        exp_pc = 9'h000;
        tgt = 9'h000;
        since = 100;
        prev_stall = 1'b0;
        req_total = 0;
        pop_total = 0;

        // Reset release with decoder ready: first valid after 3 cycles, then 1/cycle.
        do_reset();
        step(1'b1, 1'b0, 9'h000);
        chk("t1_first_req", o_imem_req, 1'b1);
        step(1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b0, 9'h000);
        chk("t1_first_pc", o_pc, 9'h000);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 9'h000);
            chk("t1_stream", o_valid, 1'b1);
        end

        // Decoder stalls: FIFO fills to exactly DEPTH and fetch stops.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 9'h000);
        chk("t2_req_low", o_imem_req, 1'b0);
        chk("t2_buffered", req_total - pop_total, 4);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 9'h000);
            chk("t2_drain", o_valid, 1'b1);
        end

        // Redirect to 0x041 with 3 buffered and one response in flight.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'h000);
        step(1'b0, 1'b1, 9'h041);
        chk("t3_pre_valid", o_valid, 1'b1);
        chk("t3_pre_outstanding", req_total - pop_total, 4);
        step(1'b1, 1'b0, 9'h000);
        chk("t3_target_addr", o_imem_addr, 9'h040);
        step(1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b0, 9'h000);
        chk("t3_first_pc", o_pc, 9'h040);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 9'h000);

        // Redirect near the top of the address space: PC wraps to 0.
        step(1'b1, 1'b1, 9'h1F8);
        step(1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b0, 9'h000);
        step(1'b1, 1'b0, 9'h000);
        chk("t4_pc_1f8", o_pc, 9'h1F8);
        step(1'b1, 1'b0, 9'h000);
        chk("t4_pc_1fc", o_pc, 9'h1FC);
        step(1'b1, 1'b0, 9'h000);
        chk("t4_pc_000", o_pc, 9'h000);

        // Redirect coinciding with a pop and an arriving response.
        step(1'b1, 1'b0, 9'h000);
        chk("t5_pre_req", o_imem_req, 1'b1);
        step(1'b1, 1'b1, 9'h100);
        chk("t5_pop_valid", o_valid, 1'b1);
        step(1'b1, 1'b0, 9'h000);
        chk("t5_empty_after", o_valid, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 9'h000);

        // Randomised traffic with a reset in the middle.
        for (int i = 0; i < 400; i++) begin
            logic       r_rdy;
            logic       r_rv;
            logic [8:0] r_pc;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv = ($urandom_range(0, 19) == 0);
            r_pc = 9'($urandom_range(0, 511));
            if (i == 200) do_reset();
            step(r_rdy, r_rv, r_pc);
        end

`ifdef FETCH_PERF_CNT_EN
        // Performance counters: 7 stall cycles and 2 redirects, then a reset pulse.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 9'h000);
        chk("t6_stall_zero", o_stall_cycles, 16'd0);
        chk("t6_redir_zero", o_redirect_cnt, 16'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 9'h000);
        step(1'b1, 1'b1, 9'h020);
        step(1'b1, 1'b1, 9'h080);
        step(1'b1, 1'b0, 9'h000);
        chk("t6_stall_cnt", o_stall_cycles, 16'd7);
        chk("t6_redir_cnt", o_redirect_cnt, 16'd2);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 9'h000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
